// File: rtl/freq_counter_multi.sv
// freq_counter_multi
//   Multi-channel gated / reciprocal frequency counter behind a Wishbone
//   classic slave. Each asynchronous input is synchronised and rising-edge
//   detected. The counter then works in one of two modes:
//     gated  : counts input edges over a GATE-cycle clk_i window
//     period : counts clk_i cycles over GATE input periods
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   addr_i[5:0]       word address          dat_i / dat_o  write / read data
//   we_i, sel_i       write enable, byte lanes (ignored)
//   cyc_i, stb_i      bus cycle / strobe    ack_o, err_o   one-cycle responses
//   signal_input      NUM_CH asynchronous inputs under measurement
//   irq_o             DONE interrupt (only when FREQ_CNT_IRQ_EN is defined)
//
// Build option FREQ_CNT_IRQ_EN adds irq_o and the CTRL[3] interrupt enable.
`timescale 1ns/1ps

module freq_counter_multi #(
    parameter int NUM_CH  = 4,
    parameter int COUNT_W = 32,
    parameter int GATE_W  = 24
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [5:0]        addr_i,
    input  logic [31:0]       dat_i,
    output logic [31:0]       dat_o,
    input  logic              we_i,
    input  logic [3:0]        sel_i,
    input  logic              cyc_i,
    input  logic              stb_i,
    output logic              ack_o,
    output logic              err_o,
    input  logic [NUM_CH-1:0] signal_input
`ifdef FREQ_CNT_IRQ_EN
    ,
    output logic              irq_o
`endif
);

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_MEAS, S_DONE} state_t;
    state_t state_q;

    logic [NUM_CH-1:0]  sync1_q, sync2_q, prev_q, edge_det;
    logic               ctrl_mode, ctrl_cont, ctrl_ie;
    logic [GATE_W-1:0]  gate_reg, gate_sh, gate_last, win_cnt;
    logic [NUM_CH-1:0]  ch_en, ch_en_sh;
    logic               mode_sh;
    logic               status_done;
    logic [NUM_CH-1:0]  ovf_q;
    logic [COUNT_W-1:0] cnt_q [NUM_CH];
    logic [COUNT_W-1:0] cnt_d [NUM_CH];
    logic [COUNT_W-1:0] result_q [NUM_CH];
    logic [COUNT_W-1:0] res_val [NUM_CH];
    logic [GATE_W-1:0]  ecnt_q [NUM_CH];
    logic [GATE_W-1:0]  ecnt_d [NUM_CH];
    logic [NUM_CH-1:0]  armed_q, armed_d, fin_q, fin_d, ovf_hit, res_we;
    logic               req, mapped, ctrl_wr, status_wr, gate_wr, chen_wr;
    logic               srst, start, launch, rerun, win_end, all_fin, meas_end, busy;
    logic [31:0]        rdata;
    logic [7:0]         ovf_ext;
    logic               unused_bits;

    assign unused_bits = ^{sel_i, dat_i};

    // ---------------- bus decode ----------------
    assign req       = cyc_i & stb_i & ~ack_o & ~err_o;
    assign mapped    = (addr_i < 6'd4) || ((addr_i >= 6'd8) && (addr_i < 6'(8 + NUM_CH)));
    assign ctrl_wr   = req & we_i & (addr_i == 6'd0);
    assign status_wr = req & we_i & (addr_i == 6'd1);
    assign gate_wr   = req & we_i & (addr_i == 6'd2);
    assign chen_wr   = req & we_i & (addr_i == 6'd3);
    // SRST takes priority over a START carried in the same write.
    assign srst      = ctrl_wr & dat_i[0];
    assign start     = ctrl_wr & dat_i[7] & ~dat_i[0];

`ifdef FREQ_CNT_IRQ_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)                    ctrl_ie <= 1'b0;
        else if (ctrl_wr && !dat_i[0]) ctrl_ie <= dat_i[3];
    end
    assign irq_o = status_done & ctrl_ie;
`else
    assign ctrl_ie = 1'b0;
`endif

    always_comb begin
        ovf_ext = '0;
        ovf_ext[NUM_CH-1:0] = ovf_q;
        rdata = '0;
        case (addr_i)
            6'd0:    rdata[3:0] = {ctrl_ie, ctrl_cont, ctrl_mode, 1'b0};
            6'd1:    rdata = {16'h0, ovf_ext, 6'h0, status_done, busy};
            6'd2:    rdata[GATE_W-1:0] = gate_reg;
            6'd3:    rdata[NUM_CH-1:0] = ch_en;
            default: begin
                for (int c = 0; c < NUM_CH; c++)
                    if (addr_i == 6'(8 + c)) rdata[COUNT_W-1:0] = result_q[c];
            end
        endcase
    end

    // ---------------- measurement datapath ----------------
    assign edge_det  = sync2_q & ~prev_q;
    assign gate_last = gate_sh - 1'b1;
    assign win_end   = (win_cnt == gate_last);
    assign busy      = (state_q == S_MEAS);

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            cnt_d[c]   = cnt_q[c];
            ecnt_d[c]  = ecnt_q[c];
            armed_d[c] = armed_q[c];
            fin_d[c]   = fin_q[c];
            ovf_hit[c] = 1'b0;
            res_we[c]  = 1'b0;
            res_val[c] = cnt_q[c];
            if (busy && ch_en_sh[c]) begin
                if (!mode_sh) begin
                    if (edge_det[c] && !fin_q[c]) begin
                        if (cnt_q[c] == CNT_MAX) begin
                            ovf_hit[c] = 1'b1;
                            fin_d[c]   = 1'b1;
                        end else begin
                            cnt_d[c] = cnt_q[c] + 1'b1;
                        end
                    end
                    // An edge in the final window cycle is included.
                    if (win_end) begin
                        res_we[c]  = 1'b1;
                        res_val[c] = cnt_d[c];
                    end
                end else if (!fin_q[c]) begin
                    // The counter runs before arming too, so a silent input
                    // ends through saturation.
                    if (edge_det[c] && !armed_q[c]) begin
                        armed_d[c] = 1'b1;
                        cnt_d[c]   = '0;
                        ecnt_d[c]  = '0;
                    end else if (cnt_q[c] == CNT_MAX) begin
                        ovf_hit[c] = 1'b1;
                        fin_d[c]   = 1'b1;
                        res_we[c]  = 1'b1;
                        res_val[c] = CNT_MAX;
                    end else if (edge_det[c] && ecnt_q[c] == gate_last) begin
                        fin_d[c]   = 1'b1;
                        res_we[c]  = 1'b1;
                        res_val[c] = cnt_q[c] + 1'b1;
                    end else begin
                        cnt_d[c] = cnt_q[c] + 1'b1;
                        if (edge_det[c]) ecnt_d[c] = ecnt_q[c] + 1'b1;
                    end
                end
            end
        end
    end

    assign all_fin  = &(fin_d | ~ch_en_sh);
    assign meas_end = busy && (mode_sh ? all_fin : win_end);
    assign launch   = start && (|ch_en) && !busy;
    assign rerun    = (state_q == S_DONE) && ctrl_cont;

    // ---------------- state ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            ack_o       <= 1'b0;
            err_o       <= 1'b0;
            dat_o       <= '0;
            ctrl_mode   <= 1'b0;
            ctrl_cont   <= 1'b0;
            gate_reg    <= GATE_W'(1);
            gate_sh     <= GATE_W'(1);
            ch_en       <= '1;
            ch_en_sh    <= '1;
            mode_sh     <= 1'b0;
            state_q     <= S_IDLE;
            win_cnt     <= '0;
            status_done <= 1'b0;
            ovf_q       <= '0;
            armed_q     <= '0;
            fin_q       <= '0;
            // NOTE: the per-channel arrays are plain flops, not a RAM, so they can be reset.
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c]    <= '0;
                ecnt_q[c]   <= '0;
                result_q[c] <= '0;
            end
        end else begin
            sync1_q <= signal_input;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;

            ack_o <= req & mapped;
            err_o <= req & ~mapped;
            dat_o <= (req && mapped && !we_i) ? rdata : '0;

            if (gate_wr) gate_reg <= dat_i[GATE_W-1:0];
            if (chen_wr) ch_en    <= dat_i[NUM_CH-1:0];
            if (ctrl_wr && !dat_i[0]) begin
                ctrl_mode <= dat_i[1];
                ctrl_cont <= dat_i[2];
            end

            armed_q <= armed_d;
            fin_q   <= fin_d;
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c]  <= cnt_d[c];
                ecnt_q[c] <= ecnt_d[c];
                if (res_we[c]) result_q[c] <= res_val[c];
                if (ovf_hit[c])                      ovf_q[c] <= 1'b1;
                else if (status_wr && dat_i[8 + c]) ovf_q[c] <= 1'b0;
            end

            // Setting DONE beats a W1C in the same cycle.
            if (meas_end)                     status_done <= 1'b1;
            else if (status_wr && dat_i[1]) status_done <= 1'b0;

            if (busy) win_cnt <= win_cnt + 1'b1;

            if (launch) begin
                gate_sh  <= (gate_reg == '0) ? GATE_W'(1) : gate_reg;
                ch_en_sh <= ch_en;
                mode_sh  <= dat_i[1];
            end

            // NOTE: a later non-blocking assignment in this block overrides an
            // earlier one; the run-start and SRST clears below rely on that.
            if (launch || rerun) begin
                state_q <= S_MEAS;
                win_cnt <= '0;
                armed_q <= '0;
                fin_q   <= '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    cnt_q[c]  <= '0;
                    ecnt_q[c] <= '0;
                end
            end else if (meas_end) begin
                state_q <= S_DONE;
            end else if (state_q == S_DONE) begin
                state_q <= S_IDLE;
            end

            // Soft reset keeps GATE, CH_EN and the CTRL mode bits.
            if (srst) begin
                state_q     <= S_IDLE;
                win_cnt     <= '0;
                status_done <= 1'b0;
                ovf_q       <= '0;
                armed_q     <= '0;
                fin_q       <= '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    cnt_q[c]    <= '0;
                    ecnt_q[c]   <= '0;
                    result_q[c] <= '0;
                end
            end
        end
    end

endmodule
